// File: rtl/replay_pkg.sv
// Shared types and helpers for the replay sequencing controller.
// Sequence numbers are 12-bit and wrap modulo 4096.
package replay_pkg;

    localparam int SEQ_W = 12;

    typedef logic [SEQ_W-1:0] seq_t;

    localparam logic [1:0] ACKNAK_NONE = 2'b00;
    localparam logic [1:0] ACKNAK_ACK  = 2'b01;
    localparam logic [1:0] ACKNAK_NAK  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ACK_FWD,
        NAK_FWD,
        TO_FWD,
        REP_WAIT
    } state_t;

    function automatic seq_t seq_diff(input seq_t a, input seq_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts enabled cycles and pulses expire on the last one.
// The count restarts from zero after expiry or on clear.
module replay_timer
#(
    parameter int REPLAY_TIMEOUT = 1024
)
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(REPLAY_TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expire = enable && (count == CW'(REPLAY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/replay_sched.sv
// Replay buffer sequencing: tracks sequence numbers, validates ACK/NAK
// DLLPs, runs the replay timer and drives the buffer control pulses.
module replay_sched
    import replay_pkg::*;
#(
    parameter int WORDS_PER_TLP   = 10,
    parameter int MAX_OUTSTANDING = 8,
    parameter int REPLAY_TIMEOUT  = 1024
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             tlp_sent,
    input  logic             dllp_valid,
    input  logic             dllp_nak,
    input  logic [SEQ_W-1:0] dllp_seq,
    input  logic             buf_ready,
    output logic [1:0]       acknak,
    output logic [SEQ_W-1:0] num_to_rep,
    output logic             tim_out,
    output logic [SEQ_W-1:0] next_seq,
    output logic [SEQ_W-1:0] ackd_seq,
    output logic             tx_stall,
    output logic             retrain,
    output logic             dllp_err
);

    state_t     state, state_nxt;
    logic [1:0] replay_num, rnum_nxt, rn_src;
    seq_t       next_nxt, ackd_nxt, ntr_nxt;
    seq_t       outstanding, d, ackd_upd, out_upd;
    logic       retrain_nxt, err_nxt, seen_busy, seen_nxt;
    logic       dllp_ok, advance, tmr_clr, tmr_en, tmr_exp;

    function automatic seq_t rep_words(input seq_t n);
        logic [15:0] p;
        p = 16'(n) * 16'(WORDS_PER_TLP);
        return seq_t'(p - 16'd1);
    endfunction

    assign outstanding = seq_diff(next_seq, ackd_seq) - seq_t'(1);
    assign d           = seq_diff(dllp_seq, ackd_seq);
    assign dllp_ok     = dllp_valid && (d <= outstanding);
    assign advance     = dllp_ok && (d != '0);
    assign ackd_upd    = advance ? dllp_seq : ackd_seq;
    assign out_upd     = seq_diff(next_seq, ackd_upd) - seq_t'(1);
    assign rn_src      = advance ? 2'd0 : replay_num;

    assign tx_stall = (outstanding == seq_t'(MAX_OUTSTANDING))
                   || (state != IDLE);
    assign tmr_en   = (state == IDLE) && (outstanding != '0);

    replay_timer #(
        .REPLAY_TIMEOUT(REPLAY_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clr || (outstanding == '0)),
        .enable (tmr_en),
        .expire (tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            next_seq   <= '0;
            ackd_seq   <= '1;
            replay_num <= '0;
            num_to_rep <= '0;
            retrain    <= 1'b0;
            dllp_err   <= 1'b0;
            seen_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            next_seq   <= next_nxt;
            ackd_seq   <= ackd_nxt;
            replay_num <= rnum_nxt;
            num_to_rep <= ntr_nxt;
            retrain    <= retrain_nxt;
            dllp_err   <= err_nxt;
            seen_busy  <= seen_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        next_nxt    = next_seq;
        ackd_nxt    = ackd_seq;
        rnum_nxt    = replay_num;
        ntr_nxt     = num_to_rep;
        retrain_nxt = 1'b0;
        err_nxt     = 1'b0;
        seen_nxt    = seen_busy;
        tmr_clr     = 1'b0;
        acknak      = ACKNAK_NONE;
        tim_out     = 1'b0;
        if (tlp_sent && !tx_stall) begin
            next_nxt = next_seq + seq_t'(1);
        end
        unique case (state)
            IDLE: begin
                seen_nxt = 1'b0;
                err_nxt  = dllp_valid && !dllp_ok;
                // A NAK that still leaves TLPs outstanding starts a replay;
                // otherwise any forward-moving DLLP acts as an ACK.
                if (dllp_ok && dllp_nak && (out_upd != '0)) begin
                    ackd_nxt    = ackd_upd;
                    rnum_nxt    = rn_src + 2'd1;
                    retrain_nxt = (rn_src == 2'd3);
                    ntr_nxt     = rep_words(out_upd);
                    tmr_clr     = 1'b1;
                    state_nxt   = NAK_FWD;
                end else if (advance) begin
                    ackd_nxt  = dllp_seq;
                    rnum_nxt  = 2'd0;
                    tmr_clr   = 1'b1;
                    state_nxt = ACK_FWD;
                end else if (tmr_exp) begin
                    rnum_nxt    = replay_num + 2'd1;
                    retrain_nxt = (replay_num == 2'd3);
                    ntr_nxt     = rep_words(outstanding);
                    state_nxt   = TO_FWD;
                end
            end
            ACK_FWD: begin
                acknak    = ACKNAK_ACK;
                state_nxt = IDLE;
            end
            NAK_FWD: begin
                acknak    = ACKNAK_NAK;
                state_nxt = REP_WAIT;
            end
            TO_FWD: begin
                tim_out   = 1'b1;
                state_nxt = REP_WAIT;
            end
            REP_WAIT: begin
                if (!buf_ready) begin
                    seen_nxt = 1'b1;
                end else if (seen_busy) begin
                    ntr_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_replay_sched.sv
// Directed bench for replay_sched: sequencing, ACK/NAK, timeouts,
// wraparound, rollover and reset during a replay.
module tb_replay_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        tlp_sent;
    logic        dllp_valid;
    logic        dllp_nak;
    logic [11:0] dllp_seq;
    logic        buf_ready;
    logic [1:0]  acknak;
    logic [11:0] num_to_rep;
    logic        tim_out;
    logic [11:0] next_seq;
    logic [11:0] ackd_seq;
    logic        tx_stall;
    logic        retrain;
    logic        dllp_err;

    int total = 0;
    int bad   = 0;

    replay_sched dut (
        .clk        (clk),
        .reset      (reset),
        .tlp_sent   (tlp_sent),
        .dllp_valid (dllp_valid),
        .dllp_nak   (dllp_nak),
        .dllp_seq   (dllp_seq),
        .buf_ready  (buf_ready),
        .acknak     (acknak),
        .num_to_rep (num_to_rep),
        .tim_out    (tim_out),
        .next_seq   (next_seq),
        .ackd_seq   (ackd_seq),
        .tx_stall   (tx_stall),
        .retrain    (retrain),
        .dllp_err   (dllp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic send_dllp(input logic nak, input logic [11:0] seq);
        dllp_valid = 1'b1;
        dllp_nak   = nak;
        dllp_seq   = seq;
        tick();
        dllp_valid = 1'b0;
        dllp_nak   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Buffer goes busy for two cycles, then idle; ends in IDLE.
    task automatic finish_replay();
        buf_ready = 1'b0;
        tick();
        tick();
        buf_ready = 1'b1;
        chk("stall_in_repwait", 16'(tx_stall), 16'd1);
        tick();
        chk("stall_after_rep", 16'(tx_stall), 16'd0);
        chk("ntr_after_rep", 16'(num_to_rep), 16'd0);
    endtask

    task automatic do_timeouts(input int cnt, input int rt_idx,
                               input int first_wait,
                               input logic [11:0] ntr);
        int n;
        for (int k = 0; k < cnt; k++) begin
            n = 0;
            while (tim_out !== 1'b1 && n < 2000) begin
                tick();
                n++;
            end
            chk("to_wait", 16'(n), (k == 0) ? 16'(first_wait) : 16'd1024);
            chk("to_pulse", 16'(tim_out), 16'd1);
            chk("to_ntr", 16'(num_to_rep), 16'(ntr));
            chk("to_retrain", 16'(retrain), (k == rt_idx) ? 16'd1 : 16'd0);
            chk("to_acknak", 16'(acknak), 16'd0);
            finish_replay();
        end
    endtask

    initial begin
        tlp_sent   = 1'b0;
        dllp_valid = 1'b0;
        dllp_nak   = 1'b0;
        dllp_seq   = '0;
        buf_ready  = 1'b1;
        do_reset();

        chk("rst_next", 16'(next_seq), 16'd0);
        chk("rst_ackd", 16'(ackd_seq), 16'd4095);
        chk("rst_stall", 16'(tx_stall), 16'd0);
        chk("rst_acknak", 16'(acknak), 16'd0);
        chk("rst_ntr", 16'(num_to_rep), 16'd0);
        chk("rst_timout", 16'(tim_out), 16'd0);
        chk("rst_err", 16'(dllp_err), 16'd0);

        // Fill to MAX_OUTSTANDING; extra pulse ignored
        tlp_sent = 1'b1;
        repeat (7) tick();
        chk("fill7_stall", 16'(tx_stall), 16'd0);
        chk("fill7_next", 16'(next_seq), 16'd7);
        tick();
        chk("fill8_stall", 16'(tx_stall), 16'd1);
        tick();
        tlp_sent = 1'b0;
        chk("fill9_next", 16'(next_seq), 16'd8);
        chk("fill9_ackd", 16'(ackd_seq), 16'd4095);

        // ACK 3 releases four TLPs
        send_dllp(1'b0, 12'd3);
        chk("ack_pulse", 16'(acknak), 16'd1);
        chk("ack_ackd", 16'(ackd_seq), 16'd3);
        tick();
        chk("ack_clear", 16'(acknak), 16'd0);
        chk("ack_unstall", 16'(tx_stall), 16'd0);

        // Duplicate ACK then NAK: replay of 4 TLPs
        send_dllp(1'b0, 12'd3);
        chk("dup_acknak", 16'(acknak), 16'd0);
        chk("dup_err", 16'(dllp_err), 16'd0);
        chk("dup_stall", 16'(tx_stall), 16'd0);
        send_dllp(1'b1, 12'd3);
        chk("nak_pulse", 16'(acknak), 16'd2);
        chk("nak_ntr", 16'(num_to_rep), 16'd39);
        chk("nak_stall", 16'(tx_stall), 16'd1);
        chk("nak_ackd", 16'(ackd_seq), 16'd3);
        finish_replay();

        // Four timeouts with 4 outstanding; rollover on the fourth
        do_reset();
        tlp_sent = 1'b1;
        repeat (4) tick();
        tlp_sent = 1'b0;
        do_timeouts(4, 3, 1021, 12'd39);

        // Walk sequence numbers to the wrap point
        do_reset();
        for (int n = 0; n < 4094; n++) begin
            tlp_sent = 1'b1;
            tick();
            tlp_sent = 1'b0;
            send_dllp(1'b0, 12'(n));
            tick();
        end
        chk("walk_next", 16'(next_seq), 16'd4094);
        chk("walk_ackd", 16'(ackd_seq), 16'd4093);
        tlp_sent = 1'b1;
        repeat (4) tick();
        tlp_sent = 1'b0;
        chk("wrap_next", 16'(next_seq), 16'd2);
        send_dllp(1'b0, 12'd0);
        chk("wrap_ack", 16'(acknak), 16'd1);
        tick();
        chk("wrap_ackd", 16'(ackd_seq), 16'd0);
        send_dllp(1'b0, 12'd5);
        chk("range_err", 16'(dllp_err), 16'd1);
        chk("range_acknak", 16'(acknak), 16'd0);
        chk("range_ackd", 16'(ackd_seq), 16'd0);
        tick();
        chk("range_err_clr", 16'(dllp_err), 16'd0);

        // NAK lands on the timer-expiry cycle
        do_reset();
        tlp_sent = 1'b1;
        repeat (4) tick();
        tlp_sent = 1'b0;
        repeat (1020) tick();
        send_dllp(1'b1, 12'd1);
        chk("race_acknak", 16'(acknak), 16'd2);
        chk("race_timout", 16'(tim_out), 16'd0);
        chk("race_ntr", 16'(num_to_rep), 16'd19);
        chk("race_ackd", 16'(ackd_seq), 16'd1);
        chk("race_retrain", 16'(retrain), 16'd0);
        tick();
        chk("race_timout2", 16'(tim_out), 16'd0);
        finish_replay();
        do_timeouts(3, 2, 1024, 12'd19);

        // Reset during a NAK replay
        do_reset();
        tlp_sent = 1'b1;
        repeat (2) tick();
        tlp_sent = 1'b0;
        send_dllp(1'b1, 12'd4095);
        chk("mid_acknak", 16'(acknak), 16'd2);
        chk("mid_ntr", 16'(num_to_rep), 16'd19);
        reset = 1'b1;
        tick();
        chk("mid_rst_acknak", 16'(acknak), 16'd0);
        chk("mid_rst_ntr", 16'(num_to_rep), 16'd0);
        chk("mid_rst_next", 16'(next_seq), 16'd0);
        chk("mid_rst_stall", 16'(tx_stall), 16'd0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
